// File: rtl/dispatch_ctrl_pkg.sv
// ============================================================================
// dispatch_ctrl_pkg : shared bus widths, opcodes and queue entry type.
// Rev 1.0
// ============================================================================
`default_nettype none

package dispatch_ctrl_pkg;

   localparam int       INST_W           = 32;
   localparam int       ADDR_W           = 32;
   localparam int       IQ_DEPTH_DEFAULT = 8;
   localparam logic     NOT_JUMP         = 1'b0;
   localparam logic [6:0] OP_LOAD        = 7'b0000011;
   localparam logic [6:0] OP_STORE       = 7'b0100011;

   typedef struct packed {
      logic [INST_W-1:0] inst;
      logic [ADDR_W-1:0] pc;
      logic              pd;
   } iq_entry_t;

   // Loads and stores go to the LSB; everything else competes for the RS.
   function automatic logic is_mem(input logic [INST_W-1:0] inst);
      return (inst[6:0] == OP_LOAD) || (inst[6:0] == OP_STORE);
   endfunction

endpackage

`default_nettype wire

// File: rtl/dispatch_ctrl_iq_fifo.sv
// ============================================================================
// iq_fifo : circular instruction queue with head/tail pointers and count.
// Rev 1.0
// ============================================================================
`default_nettype none

module iq_fifo
   import dispatch_ctrl_pkg::*;
#(
   parameter int DEPTH = IQ_DEPTH_DEFAULT
) (
   input  logic      clk,
   input  logic      rst,
   input  logic      rdy,
   input  logic      clr,
   input  logic      wr_en,
   input  iq_entry_t wr_data,
   input  logic      rd_en,
   output iq_entry_t rd_data,
   output logic      empty,
   output logic      full
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [PTR_W-1:0] r_head;
   logic [PTR_W-1:0] r_tail;
   logic [CNT_W-1:0] r_count;
   iq_entry_t        r_mem [DEPTH];

   logic w_do_wr;
   logic w_do_rd;

   assign full    = (r_count == CNT_W'(DEPTH));
   assign empty   = (r_count == '0);
   assign w_do_wr = wr_en && !full;
   assign w_do_rd = rd_en && !empty;
   assign rd_data = r_mem[r_head];

   always_ff @(posedge clk) begin
      if (rst) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else if (rdy) begin
         if (clr) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
         end else begin
            if (w_do_wr) r_tail <= r_tail + PTR_W'(1);
            if (w_do_rd) r_head <= r_head + PTR_W'(1);
            case ({w_do_wr, w_do_rd})
               2'b10:   r_count <= r_count + CNT_W'(1);
               2'b01:   r_count <= r_count - CNT_W'(1);
               default: r_count <= r_count;
            endcase
         end
      end
   end

   // Storage is deliberately left unreset; count alone defines validity.
   always_ff @(posedge clk) begin
      if (rdy && !clr && w_do_wr) r_mem[r_tail] <= wr_data;
   end

endmodule

`default_nettype wire

// File: rtl/dispatch_ctrl.sv
// ============================================================================
// dispatch_ctrl : in-order instruction queue feeding the decoder, stalled by
//                 ROB / RS / LSB back-pressure.  Rev 1.0
// ============================================================================
`default_nettype none

module dispatch_ctrl
   import dispatch_ctrl_pkg::*;
#(
   parameter int IQ_DEPTH = IQ_DEPTH_DEFAULT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rdy,
   input  logic              iIF_en,
   input  logic [INST_W-1:0] iIF_inst,
   input  logic [ADDR_W-1:0] iIF_pc,
   input  logic              iIF_pd,
   output logic              oIF_full,
   input  logic              iROB_full,
   input  logic              iRS_full,
   input  logic              iLSB_full,
   input  logic              iROB_clr,
   output logic              oDEC_en,
   output logic [INST_W-1:0] oDEC_inst,
   output logic [ADDR_W-1:0] oDEC_pc,
   output logic              oDEC_pd
);

   iq_entry_t w_wr_data;
   iq_entry_t w_head;
   logic      w_empty;
   logic      w_full;
   logic      w_head_mem;
   logic      w_dispatch;

   assign w_wr_data = '{inst: iIF_inst, pc: iIF_pc, pd: iIF_pd};

   iq_fifo #(
      .DEPTH (IQ_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .rdy     (rdy),
      .clr     (iROB_clr),
      .wr_en   (iIF_en),
      .wr_data (w_wr_data),
      .rd_en   (w_dispatch),
      .rd_data (w_head),
      .empty   (w_empty),
      .full    (w_full)
   );

   assign oIF_full   = w_full;
   assign w_head_mem = is_mem(w_head.inst);

   // Only the head is examined, so a stalled head blocks everything behind it.
   assign w_dispatch = rdy && !w_empty && !iROB_clr && !iROB_full &&
                       (w_head_mem ? !iLSB_full : !iRS_full);

   always_ff @(posedge clk) begin
      if (rst) begin
         oDEC_en   <= 1'b0;
         oDEC_inst <= '0;
         oDEC_pc   <= '0;
         oDEC_pd   <= NOT_JUMP;
      end else if (rdy) begin
         oDEC_en <= w_dispatch;
         if (w_dispatch) begin
            oDEC_inst <= w_head.inst;
            oDEC_pc   <= w_head.pc;
            oDEC_pd   <= w_head.pd;
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_dispatch_ctrl.sv
// ============================================================================
// tb_dispatch_ctrl : directed self-checking bench for dispatch_ctrl.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_dispatch_ctrl;

   localparam logic [31:0] ADDI = 32'h0000_0013;
   localparam logic [31:0] ADD  = 32'h0000_0033;
   localparam logic [31:0] LW   = 32'h0000_2003;
   localparam logic [31:0] SW   = 32'h0000_2023;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        rdy = 1'b1;
   logic        iIF_en = 1'b0;
   logic [31:0] iIF_inst = '0;
   logic [31:0] iIF_pc = '0;
   logic        iIF_pd = 1'b0;
   logic        oIF_full;
   logic        iROB_full = 1'b0;
   logic        iRS_full = 1'b0;
   logic        iLSB_full = 1'b0;
   logic        iROB_clr = 1'b0;
   logic        oDEC_en;
   logic [31:0] oDEC_inst;
   logic [31:0] oDEC_pc;
   logic        oDEC_pd;

   int n_cmp = 0;
   int n_err = 0;

   dispatch_ctrl #(.IQ_DEPTH(8)) dut (
      .clk(clk), .rst(rst), .rdy(rdy),
      .iIF_en(iIF_en), .iIF_inst(iIF_inst), .iIF_pc(iIF_pc), .iIF_pd(iIF_pd),
      .oIF_full(oIF_full),
      .iROB_full(iROB_full), .iRS_full(iRS_full), .iLSB_full(iLSB_full),
      .iROB_clr(iROB_clr),
      .oDEC_en(oDEC_en), .oDEC_inst(oDEC_inst), .oDEC_pc(oDEC_pc), .oDEC_pd(oDEC_pd)
   );

   always #5 clk = ~clk;

   // Advance one edge; outputs are then sampled 1 time unit after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [31:0] inst, input logic [31:0] pc, input logic pd);
      iIF_en = 1'b1; iIF_inst = inst; iIF_pc = pc; iIF_pd = pd;
      step();
      iIF_en = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; rdy = 1'b0; iROB_clr = 1'b1;
      step(); step();
      rst = 1'b0; rdy = 1'b1; iROB_clr = 1'b0;
      n_cmp++; if (oDEC_en !== 1'b0) begin n_err++; $display("FAIL reset_en: got %b want 0", oDEC_en); end
      n_cmp++; if (oDEC_inst !== 32'h0) begin n_err++; $display("FAIL reset_inst: got %h want 0", oDEC_inst); end
      n_cmp++; if (oDEC_pc !== 32'h0) begin n_err++; $display("FAIL reset_pc: got %h want 0", oDEC_pc); end
      n_cmp++; if (oDEC_pd !== 1'b0) begin n_err++; $display("FAIL reset_pd: got %b want 0", oDEC_pd); end
      n_cmp++; if (oIF_full !== 1'b0) begin n_err++; $display("FAIL reset_full: got %b want 0", oIF_full); end
   endtask

   task automatic test_latency();
      push(ADDI, 32'h0, 1'b1);
      n_cmp++; if (oDEC_en !== 1'b0) begin n_err++; $display("FAIL lat_cycle1_en: got %b want 0", oDEC_en); end
      step();
      n_cmp++; if (oDEC_en !== 1'b1) begin n_err++; $display("FAIL lat_cycle2_en: got %b want 1", oDEC_en); end
      n_cmp++; if (oDEC_pc !== 32'h0) begin n_err++; $display("FAIL lat_pc: got %h want 0", oDEC_pc); end
      n_cmp++; if (oDEC_inst !== ADDI) begin n_err++; $display("FAIL lat_inst: got %h want %h", oDEC_inst, ADDI); end
      n_cmp++; if (oDEC_pd !== 1'b1) begin n_err++; $display("FAIL lat_pd: got %b want 1", oDEC_pd); end
      step();
      n_cmp++; if (oDEC_en !== 1'b0) begin n_err++; $display("FAIL lat_after_en: got %b want 0", oDEC_en); end
      n_cmp++; if (oDEC_inst !== ADDI) begin n_err++; $display("FAIL lat_hold_inst: got %h want %h", oDEC_inst, ADDI); end
   endtask

   task automatic test_full();
      iRS_full = 1'b1;
      for (int i = 0; i < 8; i++) begin
         n_cmp++; if (oIF_full !== 1'b0) begin n_err++; $display("FAIL full_early: entry %0d got %b want 0", i, oIF_full); end
         push(ADDI, 32'h100 + 32'(4 * i), i[0]);
         n_cmp++; if (oDEC_en !== 1'b0) begin n_err++; $display("FAIL full_stall_en: entry %0d got %b want 0", i, oDEC_en); end
      end
      n_cmp++; if (oIF_full !== 1'b1) begin n_err++; $display("FAIL full_after8: got %b want 1", oIF_full); end
      push(ADDI, 32'hDEAD, 1'b0);
      n_cmp++; if (oIF_full !== 1'b1) begin n_err++; $display("FAIL full_after9: got %b want 1", oIF_full); end
      // Enqueue while full alongside the first dispatch: must be dropped.
      iRS_full = 1'b0;
      push(ADDI, 32'hBAD0, 1'b0);
      n_cmp++; if (oIF_full !== 1'b0) begin n_err++; $display("FAIL full_release: got %b want 0", oIF_full); end
      for (int i = 0; i < 8; i++) begin
         n_cmp++; if (oDEC_en !== 1'b1) begin n_err++; $display("FAIL full_drain_en: slot %0d got %b want 1", i, oDEC_en); end
         n_cmp++; if (oDEC_pc !== 32'h100 + 32'(4 * i)) begin n_err++; $display("FAIL full_drain_pc: slot %0d got %h want %h", i, oDEC_pc, 32'h100 + 32'(4 * i)); end
         n_cmp++; if (oDEC_pd !== i[0]) begin n_err++; $display("FAIL full_drain_pd: slot %0d got %b want %b", i, oDEC_pd, i[0]); end
         step();
      end
      n_cmp++; if (oDEC_en !== 1'b0) begin n_err++; $display("FAIL full_no_extra: got %b pc %h want en 0", oDEC_en, oDEC_pc); end
   endtask

   task automatic test_in_order();
      iLSB_full = 1'b1;
      push(LW, 32'h200, 1'b0);
      push(ADD, 32'h204, 1'b0);
      for (int i = 0; i < 3; i++) begin
         n_cmp++; if (oDEC_en !== 1'b0) begin n_err++; $display("FAIL order_blocked: cycle %0d got %b want 0", i, oDEC_en); end
         step();
      end
      iLSB_full = 1'b0;
      iRS_full  = 1'b1;
      step();
      n_cmp++; if (oDEC_en !== 1'b1 || oDEC_pc !== 32'h200) begin n_err++; $display("FAIL order_lw: got en %b pc %h want en 1 pc 200", oDEC_en, oDEC_pc); end
      step();
      n_cmp++; if (oDEC_en !== 1'b0) begin n_err++; $display("FAIL order_add_rs_stall: got %b want 0", oDEC_en); end
      iRS_full = 1'b0;
      step();
      n_cmp++; if (oDEC_en !== 1'b1 || oDEC_pc !== 32'h204) begin n_err++; $display("FAIL order_add: got en %b pc %h want en 1 pc 204", oDEC_en, oDEC_pc); end
      step();
      n_cmp++; if (oDEC_en !== 1'b0) begin n_err++; $display("FAIL order_tail: got %b want 0", oDEC_en); end
   endtask

   task automatic test_flush();
      iRS_full = 1'b1;
      for (int i = 0; i < 5; i++) push(ADDI, 32'h300 + 32'(4 * i), 1'b0);
      iRS_full = 1'b0; iROB_clr = 1'b1;
      push(ADDI, 32'h3FF, 1'b1);
      iROB_clr = 1'b0;
      n_cmp++; if (oDEC_en !== 1'b0) begin n_err++; $display("FAIL flush_en: got %b want 0", oDEC_en); end
      n_cmp++; if (oIF_full !== 1'b0) begin n_err++; $display("FAIL flush_full: got %b want 0", oIF_full); end
      for (int i = 0; i < 3; i++) begin
         step();
         n_cmp++; if (oDEC_en !== 1'b0) begin n_err++; $display("FAIL flush_empty: cycle %0d got en %b pc %h want en 0", i, oDEC_en, oDEC_pc); end
      end
      push(SW, 32'h380, 1'b0);
      step();
      n_cmp++; if (oDEC_en !== 1'b1 || oDEC_pc !== 32'h380) begin n_err++; $display("FAIL flush_restart: got en %b pc %h want en 1 pc 380", oDEC_en, oDEC_pc); end
      step();
      n_cmp++; if (oDEC_en !== 1'b0) begin n_err++; $display("FAIL flush_restart_single: got en %b pc %h want en 0", oDEC_en, oDEC_pc); end
   endtask

   task automatic test_reset_midop();
      iRS_full = 1'b1;
      for (int i = 0; i < 3; i++) push(ADDI, 32'h500 + 32'(4 * i), 1'b0);
      rst = 1'b1; rdy = 1'b0;
      step();
      rst = 1'b0; rdy = 1'b1; iRS_full = 1'b0;
      n_cmp++; if (oDEC_pc !== 32'h0 || oDEC_inst !== 32'h0) begin n_err++; $display("FAIL midrst_regs: got pc %h inst %h want 0 0", oDEC_pc, oDEC_inst); end
      for (int i = 0; i < 3; i++) begin
         step();
         n_cmp++; if (oDEC_en !== 1'b0) begin n_err++; $display("FAIL midrst_discard: cycle %0d got en %b pc %h want en 0", i, oDEC_en, oDEC_pc); end
      end
   endtask

   task automatic test_freeze();
      iRS_full = 1'b1;
      for (int i = 0; i < 3; i++) push(ADDI, 32'h400 + 32'(4 * i), 1'b0);
      iRS_full = 1'b0;
      step();
      n_cmp++; if (oDEC_en !== 1'b1 || oDEC_pc !== 32'h400) begin n_err++; $display("FAIL frz_first: got en %b pc %h want en 1 pc 400", oDEC_en, oDEC_pc); end
      rdy = 1'b0; iIF_en = 1'b1; iIF_inst = ADDI; iIF_pc = 32'h4FF;
      for (int i = 0; i < 3; i++) begin
         iROB_clr = (i == 1);
         step();
         n_cmp++; if (oDEC_en !== 1'b1 || oDEC_pc !== 32'h400) begin n_err++; $display("FAIL frz_hold: cycle %0d got en %b pc %h want en 1 pc 400", i, oDEC_en, oDEC_pc); end
      end
      rdy = 1'b1; iROB_clr = 1'b0; iIF_en = 1'b0;
      step();
      n_cmp++; if (oDEC_en !== 1'b1 || oDEC_pc !== 32'h404) begin n_err++; $display("FAIL frz_resume1: got en %b pc %h want en 1 pc 404", oDEC_en, oDEC_pc); end
      step();
      n_cmp++; if (oDEC_en !== 1'b1 || oDEC_pc !== 32'h408) begin n_err++; $display("FAIL frz_resume2: got en %b pc %h want en 1 pc 408", oDEC_en, oDEC_pc); end
      step();
      n_cmp++; if (oDEC_en !== 1'b0) begin n_err++; $display("FAIL frz_drained: got en %b pc %h want en 0", oDEC_en, oDEC_pc); end
   endtask

   task automatic test_wrap();
      logic [31:0] exp_q [$];
      logic [31:0] exp_pc;
      int sent = 0;
      int got  = 0;
      for (int cyc = 0; cyc < 1000 && got < 20; cyc++) begin
         iROB_full = ($urandom_range(0, 3) == 0);
         iRS_full  = ($urandom_range(0, 2) == 0);
         iLSB_full = ($urandom_range(0, 2) == 0);
         iIF_en    = 1'b0;
         if (sent < 20 && !oIF_full && $urandom_range(0, 3) != 0) begin
            iIF_en   = 1'b1;
            iIF_inst = ($urandom_range(0, 1) == 1) ? LW : ADD;
            iIF_pc   = 32'h1000 + 32'(4 * sent);
            iIF_pd   = 1'b0;
            exp_q.push_back(iIF_pc);
            sent++;
         end
         step();
         iIF_en = 1'b0;
         if (oDEC_en === 1'b1) begin
            got++;
            n_cmp++;
            if (exp_q.size() == 0) begin
               n_err++; $display("FAIL wrap_extra: got pc %h want no dispatch", oDEC_pc);
            end else begin
               exp_pc = exp_q.pop_front();
               if (oDEC_pc !== exp_pc) begin n_err++; $display("FAIL wrap_pc: got %h want %h", oDEC_pc, exp_pc); end
            end
         end
      end
      iROB_full = 1'b0; iRS_full = 1'b0; iLSB_full = 1'b0;
      n_cmp++; if (got != 20) begin n_err++; $display("FAIL wrap_count: got %0d dispatches want 20", got); end
   endtask

   initial begin
      test_reset();
      test_latency();
      test_full();
      test_in_order();
      test_flush();
      test_reset_midop();
      test_freeze();
      test_wrap();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire
